alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_pkg.sv | 16 +
 rtl/alu_ctrl_seq_fifo.sv | 49 ++++
 rtl/alu_ctrl_seq.sv | 126 ++++++++++++
 tb/tb_alu_ctrl_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and default sizing for the ALU control sequencer.
package alu_ctrl_pkg;
  localparam int OP_W_DEF  = 7;
  localparam int CW_W_DEF  = 26;
  localparam int CNT_W_DEF = 3;
  localparam int DEPTH_DEF = 2;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Decode table entry at the default widths.
  typedef struct packed {
    logic                 written;
    logic [CNT_W_DEF-1:0] cnt;
    logic [CW_W_DEF-1:0]  cw;
  } entry_t;
endpackage

// File: rtl/alu_ctrl_seq_fifo.sv
// Synchronous FIFO, any depth >= 1, async active-high reset; reads zero when empty.
module ctrl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // Push into a full FIFO is fine when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop)  rp <= inc(rp);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  assign dout = empty ? '0 : mem[rp];
endmodule

// File: rtl/alu_ctrl_seq.sv
// Opcode -> control-word sequencer: programmable decode table, optional
// extra-cycle wait per opcode, results queued in a small output FIFO.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int CW_W  = CW_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_op,
  input  logic                  cfg_we,
  input  logic [OP_W-1:0]       cfg_addr,
  input  logic [CNT_W+CW_W-1:0] cfg_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW_W-1:0]       out_cw,
  output logic [OP_W-1:0]       out_op,
  output logic                  out_err,
  output logic                  busy
);
  localparam int ENTRIES = 2**OP_W;
  localparam int RW      = CW_W + OP_W + 1;

  typedef struct packed {
    logic             written;
    logic [CNT_W-1:0] cnt;
    logic [CW_W-1:0]  cw;
  } ent_t;

  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic [OP_W-1:0] op;
    logic            err;
  } res_t;

  ent_t             tbl [ENTRIES];
  ent_t             ent;
  res_t             lk, hold, push_d, pop_d;
  logic [CNT_W-1:0] lk_cnt, ctr;
  state_t           state, state_nxt;
  logic             push, pop, full, empty, accept, space;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= {1'b1, cfg_data};
    end
  end

  // Combinational lookup sees the pre-write contents on a same-cycle write.
  assign ent = tbl[in_op];
  always_comb begin
    lk.cw  = ent.written ? ent.cw : '0;
    lk.op  = in_op;
    lk.err = !ent.written;
    lk_cnt = ent.written ? ent.cnt : '0;
  end

  assign pop      = !empty && out_ready;
  assign space    = !full || pop;
  assign in_ready = !rst && (state == IDLE) && (!full || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && lk_cnt != '0) state_nxt = WAIT;
      WAIT:    if (ctr == '0 && space)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push   = 1'b0;
    push_d = lk;
    case (state)
      IDLE: push = accept && (lk_cnt == '0);
      WAIT: begin
        push   = (ctr == '0) && space;
        push_d = hold;
      end
      default: push = 1'b0;
    endcase
  end

  // Counter is loaded with N-1 so the push lands on the Nth WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr  <= '0;
      hold <= '0;
    end else if (state == IDLE && accept && lk_cnt != '0) begin
      ctr  <= lk_cnt - CNT_W'(1);
      hold <= lk;
    end else if (state == WAIT && ctr != '0) begin
      ctr <= ctr - CNT_W'(1);
    end
  end

  ctrl_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_d),
    .pop   (pop),
    .dout  (pop_d),
    .empty (empty),
    .full  (full)
  );

  assign out_valid = !empty;
  assign out_cw    = pop_d.cw;
  assign out_op    = pop_d.op;
  assign out_err   = pop_d.err;
  assign busy      = (state == WAIT) || out_valid;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: vector table, directed corner sequences, random scoreboard.
module tb_alu_ctrl_seq;
  localparam int DEPTH = 2;

  logic        clk = 0, rst = 1, in_valid = 0, cfg_we = 0, out_ready = 1;
  logic [6:0]  in_op = 0, cfg_addr = 0;
  logic [28:0] cfg_data = 0;
  logic        in_ready, out_valid, out_err, busy;
  logic [25:0] out_cw;
  logic [6:0]  out_op;

  alu_ctrl_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw), .out_op(out_op),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [6:0] a, input logic [2:0] c, input logic [25:0] w);
    cfg_we = 1; cfg_addr = a; cfg_data = {c, w};
    step();
    cfg_we = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [6:0]  op;
    logic [2:0]  cnt;
    logic [25:0] cw;
    logic        exp_err;
    logic [25:0] exp_cw;
    int          exp_lat;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input vec_t v);
    int lat;
    if (v.wr) cfg_write(v.op, v.cnt, v.cw);
    in_valid = 1; in_op = v.op;
    chk("in_ready_idle", in_ready, 1);
    step();
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("in_ready_wait", in_ready, 0);
      chk("busy_wait", busy, 1);
      step();
      lat++;
    end
    chk("latency", lat, v.exp_lat);
    chk("out_cw", out_cw, v.exp_cw);
    chk("out_op", out_op, v.op);
    chk("out_err", out_err, v.exp_err);
    step();
    chk("drained_valid", out_valid, 0);
    chk("empty_cw_zero", out_cw, 0);
  endtask

  // Reference model for the random phase: table contents plus in-order result queue.
  logic        m_wr [128];
  logic [25:0] m_cw [128];
  logic [33:0] q[$];
  logic [33:0] exp_r, prev;
  logic        mon = 0, hold_prev = 0;

  always @(negedge clk) begin
    if (mon) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_unexpected_out", 1, 0);
        else begin
          exp_r = q.pop_front();
          chk("rand_out", {out_cw, out_op, out_err}, exp_r);
        end
      end
      if (!out_valid) chk("rand_empty_zero", {out_cw, out_op, out_err}, 0);
      if (hold_prev) chk("rand_stable", {out_valid, out_cw, out_op, out_err}, {1'b1, prev});
      hold_prev = out_valid && !out_ready;
      prev = {out_cw, out_op, out_err};
      if (in_valid && in_ready)
        q.push_back(m_wr[in_op] ? {m_cw[in_op], in_op, 1'b0} : {26'd0, in_op, 1'b1});
      if (cfg_we) begin
        m_wr[cfg_addr] = 1'b1;
        m_cw[cfg_addr] = cfg_data[25:0];
      end
      chk("rand_inflight_bound", q.size() <= DEPTH + 1, 1);
    end
  end

  initial begin
    logic [25:0] c1, c2, c3, ca, cb;
    logic        seen;
    vt[0] = '{1'b0, 7'h05, 3'd0, 26'h0,       1'b1, 26'h0,       1};
    vt[1] = '{1'b1, 7'h10, 3'd0, 26'h2AAAAAA, 1'b0, 26'h2AAAAAA, 1};
    vt[2] = '{1'b1, 7'h11, 3'd3, 26'h1234567, 1'b0, 26'h1234567, 4};
    vt[3] = '{1'b1, 7'h12, 3'd1, 26'h0F0F0F0, 1'b0, 26'h0F0F0F0, 2};
    vt[4] = '{1'b1, 7'h7F, 3'd7, 26'h3FFFFFF, 1'b0, 26'h3FFFFFF, 8};
    vt[5] = '{1'b1, 7'h00, 3'd0, 26'h0,       1'b0, 26'h0,       1};
    vt[6] = '{1'b0, 7'h41, 3'd0, 26'h0,       1'b1, 26'h0,       1};

    // Reset: outputs quiet, table write during reset must be dropped.
    cfg_we = 1; cfg_addr = 7'h41; cfg_data = {3'd0, 26'h0000123};
    #22;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cw", out_cw, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    cfg_we = 0;
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    step();

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Backpressure with a full buffer, then push+pop on one edge.
    c1 = 26'h0000111; c2 = 26'h0000222; c3 = 26'h0000333;
    cfg_write(7'h30, 3'd0, c1);
    cfg_write(7'h31, 3'd0, c2);
    cfg_write(7'h32, 3'd0, c3);
    out_ready = 0; in_valid = 1; in_op = 7'h30;
    step();
    in_op = 7'h31;
    step();
    in_op = 7'h32;
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_head", out_cw, c1);
    step();
    chk("bp_hold_stable", out_cw, c1);
    chk("bp_hold_in_ready", in_ready, 0);
    out_ready = 1;
    #1;
    chk("bp_ready_on_pop", in_ready, 1);
    step();
    in_valid = 0; out_ready = 0;
    #1;
    chk("bp_pp_head", out_cw, c2);
    chk("bp_pp_still_full", in_ready, 0);
    out_ready = 1;
    step();
    chk("bp_third", out_cw, c3);
    step();
    chk("bp_empty", out_valid, 0);

    // Same-cycle table write and lookup of one address.
    ca = 26'h0ABCDEF; cb = 26'h1555555;
    cfg_write(7'h20, 3'd0, cb);
    cfg_we = 1; cfg_addr = 7'h20; cfg_data = {3'd0, ca};
    in_valid = 1; in_op = 7'h20;
    step();
    cfg_we = 0; in_valid = 0;
    chk("coll_valid", out_valid, 1);
    chk("coll_old_cw", out_cw, cb);
    step();
    run_vec('{1'b0, 7'h20, 3'd0, 26'h0, 1'b0, ca, 1});

    // Reset one cycle into a long op: result dropped, table wiped.
    cfg_write(7'h40, 3'd5, 26'h0777777);
    in_valid = 1; in_op = 7'h40;
    step();
    in_valid = 0;
    step();
    rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    step();
    rst = 0;
    #1;
    chk("midrst_release_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    chk("midrst_no_output", seen, 0);
    run_vec('{1'b0, 7'h40, 3'd0, 26'h0, 1'b1, 26'h0, 1});
    run_vec('{1'b0, 7'h10, 3'd0, 26'h0, 1'b1, 26'h0, 1});

    // Random traffic against the scoreboard, starting from a clean table.
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 128; i++) begin m_wr[i] = 0; m_cw[i] = 0; end
    hold_prev = 0;
    mon = 1;
    for (int c = 0; c < 1500; c++) begin
      in_valid  = $urandom % 2;
      in_op     = 7'($urandom % 16);
      out_ready = ($urandom % 4) != 0;
      cfg_we    = ($urandom % 4) == 0;
      cfg_addr  = 7'($urandom % 16);
      cfg_data  = {3'($urandom % 4), 26'($urandom)};
      step();
    end
    in_valid = 0; cfg_we = 0; out_ready = 1;
    repeat (30) step();
    mon = 0;
    chk("rand_drained", q.size(), 0);
    chk("rand_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
